// File: rtl/cdc_handshake_sender.sv
// cdc_handshake_sender: holds one word stable and runs a four-phase req/ack handshake toward a remote clock domain
module cdc_handshake_sender #(
  parameter int DATA_WIDTH     = 8,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] xfer_data,
  output logic                  xfer_req,
  input  logic                  ack_sync,
  input  logic                  timeout_clear,
  output logic                  timeout,
  output logic                  busy,
  output logic [15:0]           xfer_count
);
  // setup counter runs 0..SETUP_CYCLES-1, wait counter 0..TIMEOUT_CYCLES
  localparam int SW = (SETUP_CYCLES < 2) ? 1 : $clog2(SETUP_CYCLES);
  localparam int WW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETUP, REQ, REL} state_t;
  state_t                state_q, state_d;
  logic [SW-1:0]         setup_q, setup_d;
  logic [WW-1:0]         wait_q, wait_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  req_q, req_d;
  logic                  timeout_q, timeout_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  accept, setup_done, waiting, wait_sat, wait_hit;
  // a stale ack left in IDLE blocks new words until the remote side releases it
  assign in_ready   = (state_q == IDLE) && !ack_sync;
  assign busy       = state_q != IDLE;
  assign accept     = in_ready && in_valid;
  assign setup_done = setup_q == SW'(SETUP_CYCLES - 1);
  assign waiting    = (state_q == REQ && !ack_sync) || (state_q == REL && ack_sync);
  assign wait_sat   = wait_q == WW'(TIMEOUT_CYCLES);
  // timeout fires once, on the cycle the wait counter reaches the limit
  assign wait_hit   = (TIMEOUT_CYCLES != 0) && waiting && !wait_sat &&
                      (32'(wait_q) + 32'd1 == 32'(TIMEOUT_CYCLES));
  assign xfer_data  = data_q;
  assign xfer_req   = req_q;
  assign timeout    = timeout_q;
  assign xfer_count = cnt_q;
  // next-state for the handshake FSM, its counters and registered outputs
  always_comb begin
    state_d = state_q;
    setup_d = setup_q;
    wait_d  = wait_q;
    data_d  = data_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SETUP;
        setup_d = '0;
        data_d  = in_data;
      end
      SETUP: if (setup_done) begin
        state_d = REQ;
        req_d   = 1'b1;
        wait_d  = '0;
      end else setup_d = setup_q + 1'b1;
      REQ: if (ack_sync) begin
        state_d = REL;
        req_d   = 1'b0;
        cnt_d   = cnt_q + 16'd1;
        wait_d  = '0;
      end
      REL: if (!ack_sync) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (waiting && !wait_sat) wait_d = wait_q + 1'b1;
    timeout_d = wait_hit || (timeout_q && !timeout_clear);
  end
  // state registers with asynchronous reset so req drops immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      setup_q   <= '0;
      wait_q    <= '0;
      data_q    <= '0;
      req_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      setup_q   <= setup_d;
      wait_q    <= wait_d;
      data_q    <= data_d;
      req_q     <= req_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_cdc_handshake_sender.sv
// tb_cdc_handshake_sender: vector table plus scoreboard of handed-over words
module tb_cdc_handshake_sender;
  logic        clk = 1'b0;
  logic        reset, in_valid, ack_sync, timeout_clear;
  logic [7:0]  in_data;
  logic        in_ready, xfer_req, timeout, busy;
  logic [7:0]  xfer_data;
  logic [15:0] xfer_count;
  logic [15:0] exp_cnt;
  logic        req_prev;
  logic [7:0]  exp_q[$];
  int          total = 0, bad = 0;

  typedef struct {
    logic v; logic [7:0] d; logic ack;
    logic rdy; logic bsy; logic req; logic [7:0] data; logic [15:0] cnt;
  } vec_t;
  vec_t tbl[9];

  cdc_handshake_sender #(.DATA_WIDTH(8), .SETUP_CYCLES(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .xfer_data(xfer_data), .xfer_req(xfer_req), .ack_sync(ack_sync),
    .timeout_clear(timeout_clear), .timeout(timeout), .busy(busy), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // every rising req presents a word that must match the oldest accepted one
  task automatic tick();
    logic [7:0] w;
    @(posedge clk);
    #1;
    if (xfer_req && !req_prev) begin
      if (exp_q.size() == 0) check("sb_empty", 32'(xfer_data), 32'hFFFF_FFFF);
      else begin
        w = exp_q.pop_front();
        check("sb_word", 32'(xfer_data), 32'(w));
      end
    end
    req_prev = xfer_req;
  endtask

  task automatic start(input logic [7:0] w, input logic keep);
    int n;
    in_valid = 1'b1;
    in_data  = w;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    check("accept_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(w);
    tick();
    check("data_load", 32'(xfer_data), 32'(w));
    check("busy_accept", 32'(busy), 32'd1);
    in_valid = keep;
    n = 0;
    while (!xfer_req && n < 20) begin tick(); n++; end
    check("req_rise", 32'(xfer_req), 32'd1);
  endtask

  task automatic ack_phase(input logic [7:0] w);
    ack_sync = 1'b1;
    tick();
    exp_cnt++;
    check("req_fall", 32'(xfer_req), 32'd0);
    check("count", 32'(xfer_count), 32'(exp_cnt));
    check("data_rel", 32'(xfer_data), 32'(w));
    ack_sync = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic xfer(input logic [7:0] w, input int dly, input logic keep);
    start(w, keep);
    for (int i = 0; i < dly; i++) begin
      tick();
      check("data_hold_req", 32'(xfer_data), 32'(w));
    end
    ack_phase(w);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; ack_sync = 1'b0; timeout_clear = 1'b0;
    req_prev = 1'b0;
    exp_cnt = 16'd0;
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 16'd0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 16'd0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 16'd0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 16'd0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 16'd0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 16'd1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 16'd1};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 16'd1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 16'd1};
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(xfer_req), 32'd0);
    check("rst_data", 32'(xfer_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(xfer_count), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    reset = 1'b0;
    // single transfer, ack three cycles after req
    for (int i = 0; i < 9; i++) begin
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      ack_sync = tbl[i].ack;
      #1;
      if (in_valid && in_ready) exp_q.push_back(in_data);
      tick();
      check($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      check($sformatf("vec%0d_req", i), 32'(xfer_req), 32'(tbl[i].req));
      check($sformatf("vec%0d_data", i), 32'(xfer_data), 32'(tbl[i].data));
      check($sformatf("vec%0d_count", i), 32'(xfer_count), 32'(tbl[i].cnt));
    end
    exp_cnt = 16'd1;
    // back-to-back stream with in_valid held high
    for (int i = 1; i <= 16; i++) xfer(8'(i), i % 3, 1'b1);
    in_valid = 1'b0;
    check("stream_count", 32'(xfer_count), 32'd17);
    // stale ack in IDLE blocks acceptance
    ack_sync = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stale_ready", 32'(in_ready), 32'd0);
      check("stale_busy", 32'(busy), 32'd0);
    end
    check("stale_data", 32'(xfer_data), 32'h10);
    ack_sync = 1'b0;
    #1;
    check("stale_release_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(8'h77);
    tick();
    in_valid = 1'b0;
    check("stale_accept", 32'(xfer_data), 32'h77);
    check("stale_accept_busy", 32'(busy), 32'd1);
    tick(); tick();
    check("stale_req", 32'(xfer_req), 32'd1);
    ack_phase(8'h77);
    // timeout with a late ack, then clear
    start(8'h5A, 1'b0);
    repeat (7) tick();
    check("to_before", 32'(timeout), 32'd0);
    tick();
    check("to_set", 32'(timeout), 32'd1);
    check("to_still_req", 32'(xfer_req), 32'd1);
    repeat (3) tick();
    check("to_sticky", 32'(timeout), 32'd1);
    check("to_wait_busy", 32'(busy), 32'd1);
    timeout_clear = 1'b1;
    tick();
    timeout_clear = 1'b0;
    check("to_clear", 32'(timeout), 32'd0);
    check("to_no_reset", 32'(xfer_req), 32'd1);
    ack_phase(8'h5A);
    // clear in the same cycle as a set: set wins
    start(8'h6B, 1'b0);
    repeat (7) tick();
    timeout_clear = 1'b1;
    tick();
    check("to_set_wins", 32'(timeout), 32'd1);
    tick();
    timeout_clear = 1'b0;
    check("to_clear2", 32'(timeout), 32'd0);
    ack_phase(8'h6B);
    // asynchronous reset in REQ
    start(8'h3C, 1'b0);
    check("pre_rst_data", 32'(xfer_data), 32'h3C);
    #2;
    reset = 1'b1;
    #1;
    check("arst_req", 32'(xfer_req), 32'd0);
    check("arst_data", 32'(xfer_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_count", 32'(xfer_count), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    req_prev = 1'b0;
    exp_cnt = 16'd0;
    // counter wrap
    xfer(8'h11, 0, 1'b0);
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    check("wrap_preload", 32'(xfer_count), 32'hFFFF);
    exp_cnt = 16'hFFFF;
    xfer(8'h22, 1, 1'b0);
    check("wrap_zero", 32'(xfer_count), 32'h0000);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
